// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with count-derived status flags, sticky errors,
// and selectable standard or first-word-fall-through read timing.
module sync_fifo_v2 #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  bit FWFT       = 1'b0,
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_ready_s,
  input  logic                  i_ready_m,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_dataout,
  input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
  output logic                  o_full,
  output logic                  o_almostfull,
  output logic                  o_empty,
  output logic                  o_almostempty,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 push, pop;

  assign o_full        = (count_q == CNT_MAX);
  assign o_empty       = (count_q == '0);
  assign o_almostfull  = (count_q >= i_almostfull_lvl);
  assign o_almostempty = (count_q <= i_almostempty_lvl);
  assign o_ready_s     = !o_full;
  assign o_valid_m     = !o_empty;
  assign o_count       = count_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = udf_q;

  assign push = i_valid_s && !o_full;
  assign pop  = i_ready_m && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (i_valid_s & o_full);
    // a push landing on an empty FIFO makes the pop merely early
    udf_d    = udf_q | (i_ready_m & o_empty & !i_valid_s);
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush) begin
      mem_q[wr_ptr_q] <= i_datain;
    end
  end

  if (FWFT) begin : g_fwft
    assign o_dataout = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        dout_q <= '0;
      end else if (pop && !i_flush) begin
        dout_q <= mem_q[rd_ptr_q];
      end
    end

    assign o_dataout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: three instances (8 std, 8 fwft, 5 std)
// share stimulus and are compared against a queue model each cycle.
module tb_sync_fifo_v2;

  localparam int SZ = 256;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_flush = 1'b0;
  logic       i_valid_s = 1'b0;
  logic       i_ready_m = 1'b0;
  logic [7:0] i_datain = '0;
  logic [3:0] af_lvl = 4'd6;
  logic [3:0] ae_lvl = 4'd2;
  logic [2:0] af_lvl5 = 3'd6;
  logic [2:0] ae_lvl5 = 3'd2;

  logic [2:0] rdy, vld, full, af, emp, ae, ovf, udf;
  logic [7:0] dout0, dout1, dout2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  always #5 i_clk = ~i_clk;

  sync_fifo_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(1'b0)) u0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid_s(i_valid_s), .i_datain(i_datain), .o_ready_s(rdy[0]),
    .i_ready_m(i_ready_m), .o_valid_m(vld[0]), .o_dataout(dout0),
    .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl),
    .o_full(full[0]), .o_almostfull(af[0]), .o_empty(emp[0]),
    .o_almostempty(ae[0]), .o_count(cnt0),
    .o_overflow(ovf[0]), .o_underflow(udf[0]));

  sync_fifo_v2 #(.FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(1'b1)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid_s(i_valid_s), .i_datain(i_datain), .o_ready_s(rdy[1]),
    .i_ready_m(i_ready_m), .o_valid_m(vld[1]), .o_dataout(dout1),
    .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl),
    .o_full(full[1]), .o_almostfull(af[1]), .o_empty(emp[1]),
    .o_almostempty(ae[1]), .o_count(cnt1),
    .o_overflow(ovf[1]), .o_underflow(udf[1]));

  sync_fifo_v2 #(.FIFO_DEPTH(5), .DATA_WIDTH(8), .FWFT(1'b0)) u2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid_s(i_valid_s), .i_datain(i_datain), .o_ready_s(rdy[2]),
    .i_ready_m(i_ready_m), .o_valid_m(vld[2]), .o_dataout(dout2),
    .i_almostfull_lvl(af_lvl5), .i_almostempty_lvl(ae_lvl5),
    .o_full(full[2]), .o_almostfull(af[2]), .o_empty(emp[2]),
    .o_almostempty(ae[2]), .o_count(cnt2),
    .o_overflow(ovf[2]), .o_underflow(udf[2]));

  // reference model: linear store with head/tail counters per instance
  logic [7:0] mdat [3][SZ];
  int         head [3];
  int         tail [3];
  logic       movf [3];
  logic       mudf [3];
  logic [7:0] mout [3];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

  function automatic int depth_of(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      head[k] = tail[k];
      movf[k] = 1'b0;
      mudf[k] = 1'b0;
      mout[k] = 8'h00;
    end
  endtask

  task automatic model_edge(input logic v, input logic r,
                            input logic [7:0] d, input logic f);
    for (int k = 0; k < 3; k++) begin
      int n = tail[k] - head[k];
      int dp = depth_of(k);
      if (f) begin
        head[k] = tail[k];
        movf[k] = 1'b0;
        mudf[k] = 1'b0;
      end else begin
        if (v && n == dp) movf[k] = 1'b1;
        if (r && n == 0 && !v) mudf[k] = 1'b1;
        if (r && n > 0) begin
          mout[k] = mdat[k][head[k] % SZ];
          head[k]++;
        end
        if (v && n < dp) begin
          mdat[k][tail[k] % SZ] = d;
          tail[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int n = tail[k] - head[k];
      int dp = depth_of(k);
      logic [3:0] c;
      logic [7:0] dq;
      c  = (k == 0) ? cnt0 : (k == 1) ? cnt1 : {1'b0, cnt2};
      dq = (k == 0) ? dout0 : (k == 1) ? dout1 : dout2;
      chk($sformatf("count%0d", k), 32'(c), 32'(n));
      chk($sformatf("full%0d", k), 32'(full[k]), 32'(n == dp));
      chk($sformatf("empty%0d", k), 32'(emp[k]), 32'(n == 0));
      chk($sformatf("afull%0d", k), 32'(af[k]), 32'(n >= 6));
      chk($sformatf("aempty%0d", k), 32'(ae[k]), 32'(n <= 2));
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(n != dp));
      chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(n != 0));
      chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(movf[k]));
      chk($sformatf("udf%0d", k), 32'(udf[k]), 32'(mudf[k]));
      if (k == 1) begin
        if (n > 0) chk("dout1", 32'(dq), 32'(mdat[k][head[k] % SZ]));
      end else begin
        chk($sformatf("dout%0d", k), 32'(dq), 32'(mout[k]));
      end
    end
  endtask

  task automatic step(input logic v, input logic r,
                      input logic [7:0] d, input logic f);
    i_valid_s = v;
    i_ready_m = r;
    i_datain  = d;
    i_flush   = f;
    @(posedge i_clk);
    model_edge(v, r, d, f);
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    model_reset();
    #3;
    check_all();
    chk("rst_empty", 32'(emp[0]), 32'd1);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill_cnt", 32'(cnt0), 32'(i));
      chk("fill_af", 32'(af[0]), 32'(i >= 6));
    end
    chk("full8", 32'(full[0]), 32'd1);
    chk("rdy8", 32'(rdy[0]), 32'd0);

    // overflow, drain, underflow, flush
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("ovf_set", 32'(ovf[0]), 32'd1);
    chk("ovf_cnt", 32'(cnt0), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(ovf[0]), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_set", 32'(udf[0]), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("flush_ovf", 32'(ovf[0]), 32'd0);
    chk("flush_udf", 32'(udf[0]), 32'd0);

    // order and read modes
    step(1'b1, 1'b0, 8'hA1, 1'b0);
    chk("fwft_a1", 32'(dout1), 32'hA1);
    step(1'b1, 1'b0, 8'hA2, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("std_a1", 32'(dout0), 32'hA1);
    chk("fwft_a2", 32'(dout1), 32'hA2);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // push+pop at full, then at empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("pp_full_cnt", 32'(cnt0), 32'd7);
    chk("pp_full_out", 32'(dout0), 32'h10);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    chk("pp_empty_cnt", 32'(cnt0), 32'd1);
    chk("pp_empty_udf", 32'(udf[0]), 32'd0);

    // random interleaving, also wraps the depth-5 instance
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           8'($urandom), 1'($urandom_range(0, 63) == 0));
    end

    // reset mid-run at count 4
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
    chk("pre_rst_cnt", 32'(cnt0), 32'd4);
    i_valid_s = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cnt", 32'(cnt0), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst", 32'(dout0), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
